// File: rtl/board_io_pkg.sv
// Shared defaults and helpers for the board input conditioning stage.
package board_io_pkg;

    localparam int DefaultNumInputs      = 8;
    localparam int DefaultSyncStages     = 2;
    localparam int DefaultDebounceCycles = 50000;

    // Bits needed for a counter that reaches cycles (kept at least one bit wide).
    function automatic int cnt_width(input int cycles);
        if (cycles < 1) begin
            return 1;
        end else begin
            return $clog2(cycles + 1);
        end
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser, debounce counter, registered level,
// single-cycle edge pulses and a sticky edge-seen flag.
module debounce_channel
    import board_io_pkg::*;
#(
    parameter int   SyncStages     = DefaultSyncStages,
    parameter int   DebounceCycles = DefaultDebounceCycles,
    parameter logic ResetBit       = 1'b0
) (
    input  logic clk_sys_i,
    input  logic rst_sys_i,
    input  logic in_i,
    input  logic en_i,
    input  logic event_clr_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic event_o
);

    localparam int             CntW   = cnt_width(DebounceCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    logic [SyncStages-1:0] sync_r;
    logic [CntW-1:0]       cnt_r;
    logic [CntW-1:0]       cnt_nxt_s;
    logic                  level_r;
    logic                  level_nxt_s;
    logic                  rise_r;
    logic                  fall_r;
    logic                  event_r;
    logic                  sync_s;

    assign sync_s = sync_r[SyncStages-1];

    // Next level/count: bypass tracks the synchronised input, otherwise the
    // new value must persist DebounceCycles consecutive cycles.
    always_comb begin
        level_nxt_s = level_r;
        cnt_nxt_s   = cnt_r;
        if (!en_i) begin
            level_nxt_s = sync_s;
            cnt_nxt_s   = {CntW{1'b0}};
        end else if (sync_s == level_r) begin
            cnt_nxt_s   = {CntW{1'b0}};
        end else if (cnt_r == CntMax) begin
            level_nxt_s = sync_s;
            cnt_nxt_s   = {CntW{1'b0}};
        end else begin
            cnt_nxt_s   = cnt_r + CntW'(1);
        end
    end

    // Synchroniser chain and debounce state; pulses share the edge that moves level.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            sync_r  <= {SyncStages{ResetBit}};
            cnt_r   <= {CntW{1'b0}};
            level_r <= ResetBit;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            event_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SyncStages-2:0], in_i};
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            rise_r  <= level_nxt_s & ~level_r;
            fall_r  <= ~level_nxt_s & level_r;
            event_r <= (event_r & ~event_clr_i) | rise_r | fall_r;
        end
    end

    assign level_o = level_r;
    assign rise_o  = rise_r;
    assign fall_o  = fall_r;
    assign event_o = event_r;

endmodule

// File: rtl/board_input_conditioner.sv
// Conditions raw asynchronous board inputs into debounced levels, edge pulses
// and sticky event flags, one independent channel per input.
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int                   NumInputs      = DefaultNumInputs,
    parameter int                   SyncStages     = DefaultSyncStages,
    parameter int                   DebounceCycles = DefaultDebounceCycles,
    parameter logic [NumInputs-1:0] ResetValue     = '0
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_i,
    input  logic [NumInputs-1:0] in_i,
    input  logic                 en_i,
    input  logic [NumInputs-1:0] event_clr_i,
    output logic [NumInputs-1:0] level_o,
    output logic [NumInputs-1:0] rise_o,
    output logic [NumInputs-1:0] fall_o,
    output logic [NumInputs-1:0] event_o,
    output logic                 any_event_o
);

    logic [NumInputs-1:0] event_nxt_s;
    logic                 any_event_r;

    for (genvar i = 0; i < NumInputs; i++) begin : g_ch
        debounce_channel #(
            .SyncStages     (SyncStages),
            .DebounceCycles (DebounceCycles),
            .ResetBit       (ResetValue[i])
        ) u_ch (
            .clk_sys_i   (clk_sys_i),
            .rst_sys_i   (rst_sys_i),
            .in_i        (in_i[i]),
            .en_i        (en_i),
            .event_clr_i (event_clr_i[i]),
            .level_o     (level_o[i]),
            .rise_o      (rise_o[i]),
            .fall_o      (fall_o[i]),
            .event_o     (event_o[i])
        );
    end

    // Mirrors the per-channel flag update so the summary bit lands with the flags.
    assign event_nxt_s = (event_o & ~event_clr_i) | rise_o | fall_o;

    // Registered OR of the next flag vector.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            any_event_r <= 1'b0;
        end else begin
            any_event_r <= |event_nxt_s;
        end
    end

    assign any_event_o = any_event_r;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner with NumInputs=4, SyncStages=2,
// DebounceCycles=4 and hand-computed expectations.
module tb_board_input_conditioner;

    logic       clk_sys_s = 1'b0;
    logic       rst_sys_s;
    logic [3:0] in_s;
    logic       en_s;
    logic [3:0] event_clr_s;
    logic [3:0] level_s;
    logic [3:0] rise_s;
    logic [3:0] fall_s;
    logic [3:0] event_s;
    logic       any_event_s;

    int n_cmp = 0;
    int n_err = 0;

    board_input_conditioner #(
        .NumInputs      (4),
        .SyncStages     (2),
        .DebounceCycles (4),
        .ResetValue     (4'h0)
    ) dut (
        .clk_sys_i   (clk_sys_s),
        .rst_sys_i   (rst_sys_s),
        .in_i        (in_s),
        .en_i        (en_s),
        .event_clr_i (event_clr_s),
        .level_o     (level_s),
        .rise_o      (rise_s),
        .fall_o      (fall_s),
        .event_o     (event_s),
        .any_event_o (any_event_s)
    );

    always #5 clk_sys_s = ~clk_sys_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle past it.
    task automatic step();
        @(posedge clk_sys_s);
        #1;
    endtask

    int rise_cnt;
    int fall_cnt;
    int rise_at;
    logic [3:0] seen_s;

    initial begin
        rst_sys_s   = 1'b1;
        in_s        = 4'hF;
        en_s        = 1'b1;
        event_clr_s = 4'h0;

        // Reset held three cycles with all inputs high.
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_level", level_s, 4'h0);
            chk("rst_rise", rise_s, 4'h0);
            chk("rst_event", event_s, 4'h0);
        end
        chk("rst_any", any_event_s, 1'b0);
        rst_sys_s = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("rel_level_wait", level_s, 4'h0);
            chk("rel_rise_wait", rise_s, 4'h0);
        end
        step();
        chk("rel_level", level_s, 4'hF);
        chk("rel_rise", rise_s, 4'hF);
        step();
        chk("rel_rise_gone", rise_s, 4'h0);
        chk("rel_event", event_s, 4'hF);
        chk("rel_any", any_event_s, 1'b1);

        // Return everything low and clear flags.
        in_s = 4'h0;
        for (int k = 0; k < 5; k++) step();
        chk("all_fall_wait", fall_s, 4'h0);
        step();
        chk("all_fall", fall_s, 4'hF);
        chk("all_level_low", level_s, 4'h0);
        step();
        event_clr_s = 4'hF;
        step();
        event_clr_s = 4'h0;
        chk("clr_all_event", event_s, 4'h0);
        chk("clr_all_any", any_event_s, 1'b0);

        // Clean press on channel 0.
        in_s[0] = 1'b1;
        for (int k = 0; k < 5; k++) step();
        chk("press_level_wait", level_s[0], 1'b0);
        step();
        chk("press_level", level_s[0], 1'b1);
        chk("press_rise", rise_s, 4'h1);
        step();
        chk("press_rise_gone", rise_s[0], 1'b0);
        chk("press_event", event_s, 4'h1);
        for (int k = 0; k < 3; k++) step();
        chk("press_event_held", event_s[0], 1'b1);
        event_clr_s[0] = 1'b1;
        step();
        event_clr_s[0] = 1'b0;
        chk("press_event_clr", event_s[0], 1'b0);

        // Three-cycle glitch on channel 1 must be ignored.
        seen_s  = 4'h0;
        in_s[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            seen_s = seen_s | {level_s[1], rise_s[1], fall_s[1], event_s[1]};
        end
        in_s[1] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            seen_s = seen_s | {level_s[1], rise_s[1], fall_s[1], event_s[1]};
        end
        chk("glitch_quiet", seen_s, 4'h0);

        // Channel 2 bounces every two cycles, then settles high.
        rise_cnt = 0;
        fall_cnt = 0;
        rise_at  = -1;
        for (int k = 0; k < 12; k++) begin
            in_s[2] = ((k / 2) % 2 == 0) ? 1'b1 : 1'b0;
            step();
            rise_cnt += int'(rise_s[2]);
            fall_cnt += int'(fall_s[2]);
        end
        in_s[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (rise_s[2]) begin
                rise_cnt++;
                rise_at = k;
            end
            fall_cnt += int'(fall_s[2]);
        end
        chk("bounce_rise_cnt", rise_cnt, 32'd1);
        chk("bounce_fall_cnt", fall_cnt, 32'd0);
        chk("bounce_rise_at", rise_at, 32'd6);
        chk("bounce_level", level_s[2], 1'b1);

        // Clear coinciding with the rise pulse on channel 3.
        event_clr_s = 4'h4;
        step();
        event_clr_s = 4'h0;
        in_s[3] = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("coll_rise", rise_s[3], 1'b1);
        chk("coll_event_before", event_s[3], 1'b0);
        event_clr_s[3] = 1'b1;
        step();
        chk("coll_set_wins", event_s[3], 1'b1);
        step();
        event_clr_s[3] = 1'b0;
        chk("coll_clear", event_s[3], 1'b0);

        // Bypass: drop everything, clear flags, then a one-cycle blip on channel 0.
        en_s = 1'b0;
        in_s = 4'h0;
        for (int k = 0; k < 2; k++) step();
        chk("byp_level_hold", level_s, 4'hD);
        step();
        chk("byp_level_fast", level_s, 4'h0);
        chk("byp_fall_all", fall_s, 4'hD);
        step();
        event_clr_s = 4'hF;
        step();
        event_clr_s = 4'h0;
        chk("byp_event_clr", event_s, 4'h0);
        in_s[0] = 1'b1;
        step();
        in_s[0] = 1'b0;
        chk("byp_e1_level", level_s[0], 1'b0);
        step();
        chk("byp_e2_level", level_s[0], 1'b0);
        step();
        chk("byp_e3_level", level_s[0], 1'b1);
        chk("byp_e3_rise", rise_s, 4'h1);
        chk("byp_e3_fall", fall_s, 4'h0);
        step();
        chk("byp_e4_level", level_s[0], 1'b0);
        chk("byp_e4_rise", rise_s, 4'h0);
        chk("byp_e4_fall", fall_s, 4'h1);
        step();
        chk("byp_e5_fall", fall_s, 4'h0);
        chk("byp_any", any_event_s, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/board_input_conditioner.md
Name: board_input_conditioner

Overview:
- Parametrised conditioning stage for board-level asynchronous inputs (switches, buttons, spare PMOD lines) before they reach the demo system's GPI.
- Per channel: N-stage synchroniser, debouncer, registered level, single-cycle rise/fall pulses and sticky event flags with per-bit clear.
- Replaces raw {SW, BTN} wiring into gp_i. Sits in the board top, clocked by the system clock from the clock generator.

Parameters:
- NumInputs, 8, number of independent input channels (>=1)
- SyncStages, 2, synchroniser flop count per channel (>=2)
- DebounceCycles, 50000, consecutive cycles a new value must persist before level_o follows (>=1; 1 ms at 50 MHz)
- ResetValue, '0 (NumInputs bits), value loaded into synchroniser and level registers on reset

Ports:
- clk_sys_i  input  1  system clock
- rst_sys_i  input  1  synchronous, active-high reset
- in_i  input  NumInputs  raw asynchronous board inputs
- en_i  input  1  1 = debounce active; 0 = bypass (level follows synchronised input)
- event_clr_i  input  NumInputs  per-bit clear of sticky event flags
- level_o  output  NumInputs  conditioned level
- rise_o  output  NumInputs  one-cycle pulse on 0->1 change of level_o
- fall_o  output  NumInputs  one-cycle pulse on 1->0 change of level_o
- event_o  output  NumInputs  sticky "edge seen" flags
- any_event_o  output  1  OR-reduction of event_o

Behaviour:
- Clock and reset: one clock, clk_sys_i. Reset rst_sys_i is synchronous and active-high.
- Reset values:
  - sync chain = ResetValue, level_o = ResetValue
  - counters = 0
  - rise_o = fall_o = event_o = 0, any_event_o = 0
- Synchroniser: in_i passes through SyncStages flops. Its last stage is "s".
- Counter width: CntW = $clog2(DebounceCycles+1), per channel.
- Debounce, en_i=1, per channel:
  - s == level: counter <= 0.
  - s != level and counter == DebounceCycles-1: level <= s, counter <= 0.
  - s != level otherwise: counter <= counter+1.
- Debounced latency: an input change held stable reaches level_o exactly SyncStages + DebounceCycles edges after the first edge that samples it.
- Glitch rejection: a disagreement shorter than DebounceCycles cycles resets the counter. level_o is unchanged and no pulse is generated. Bouncing restarts the count on each return to the old value.
- Bypass, en_i=0:
  - level <= s every cycle; counters held at 0.
  - Latency SyncStages+1, identical to DebounceCycles=1.
  - Toggling en_i takes effect on the next edge. Switching to bypass discards the partial count.
- Edge pulses:
  - rise_o/fall_o are asserted in exactly the cycle the new level_o value is first visible, for one cycle.
  - They are registered, never combinational from in_i.
  - A channel cannot pulse on consecutive cycles unless in bypass.
- Sticky events:
  - event_o[i] <= (event_o[i] & ~event_clr_i[i]) | rise_o[i] | fall_o[i].
  - Set wins over a simultaneous clear.
  - any_event_o is registered alongside event_o (same cycle).
- Reset mid-operation: pending counts are discarded and level returns to ResetValue. No pulse is generated on reset entry or release. After release, an input differing from ResetValue goes through normal synchronise + debounce, then pulses.
- Channels are fully independent; simultaneous edges on several channels pulse together.

Decomposition:
- Package board_io_pkg:
  - default constants (DefaultDebounceCycles, DefaultSyncStages)
  - function cnt_width(int cycles) returning CntW
- Sub-module debounce_channel:
  - one channel: sync chain, counter, level, edge pulse, sticky flag
  - instantiated NumInputs times in a generate loop
- Top instance ORs the flags for any_event_o.

Test Plan:
Bench config: NumInputs=4, SyncStages=2, DebounceCycles=4, ResetValue=0.
- Reset: in_i=4'hF, rst_sys_i high 3 cycles -> during and on release level_o=0, rise_o=0, event_o=0. level_o becomes 4'hF exactly 6 edges after release, rise_o=4'hF for one cycle, any_event_o=1.
- Clean press: in_i[0] 0->1, held -> level_o[0]=1 exactly 6 edges after the sampling edge. rise_o[0] pulses 1 cycle. event_o[0] stays 1 until event_clr_i[0] pulse, then reads 0 next cycle.
- Glitch: in_i[1] high for 3 cycles, then low -> level_o[1], rise_o[1], fall_o[1], event_o[1] all stay 0.
- Bounce: in_i[2] toggles every 2 cycles for 12 cycles, then stays 1 -> exactly one rise_o[2] pulse, 6 edges after the final stable transition. No fall_o[2].
- Set/clear collision: event_clr_i[3] asserted in the same cycle as rise_o[3] -> event_o[3]=1 next cycle. A clear on the following cycle -> event_o[3]=0.
- Bypass: en_i=0, in_i[0] high for 1 cycle -> level_o[0] high for exactly 1 cycle, 3 edges later. rise_o[0] and fall_o[0] pulse in consecutive cycles.
